// File: rtl/if_id_stage.sv
// if_id_stage: MIPS fetch stage plus IF/ID pipeline register.
// Redirect priority per edge: EX branch, then stall, then ID jump, else fetch.
package if_id_pkg;
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic        valid;
  } if_id_t;
endpackage

module if_id_stage
  import if_id_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_data,
  input  logic             stall,
  input  logic             jcond,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc_plus4,
  output logic             id_valid,
  output logic [5:0]       id_opcode,
  output logic [5:0]       id_funct,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] pc_plus4;
  logic [31:0] jump_target;
  if_id_t      ifid;
  if_id_t      ifid_nxt;
  logic        do_branch;
  logic        do_stall;
  logic        do_jump;
  logic        stall_inc;
  logic        flush_inc;

  assign pc_plus4    = pc + 32'd4;
  assign jump_target = {ifid.pc_plus4[31:28],
                        ifid.instr[25:0], 2'b00};

  // Mutually exclusive selects so the decoder can stay unique.
  assign do_branch = branch_taken;
  assign do_stall  = stall & ~branch_taken;
  assign do_jump   = jcond & ifid.valid
                   & ~stall & ~branch_taken;

  always_comb begin
    pc_nxt    = pc;
    ifid_nxt  = ifid;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (1'b1)
      do_branch: begin
        pc_nxt         = branch_target & ~32'h3;
        ifid_nxt.instr = NOP_INSTR;
        ifid_nxt.valid = 1'b0;
        flush_inc      = 1'b1;
      end
      do_stall: begin
        stall_inc = 1'b1;
      end
      do_jump: begin
        pc_nxt         = jump_target;
        ifid_nxt.instr = NOP_INSTR;
        ifid_nxt.valid = 1'b0;
        flush_inc      = 1'b1;
      end
      default: begin
        pc_nxt            = pc_plus4;
        ifid_nxt.instr    = imem_data;
        ifid_nxt.pc_plus4 = pc_plus4;
        ifid_nxt.valid    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc            <= RESET_PC;
      ifid.instr    <= NOP_INSTR;
      ifid.pc_plus4 <= 32'd0;
      ifid.valid    <= 1'b0;
      stall_cnt     <= '0;
      flush_cnt     <= '0;
    end else begin
      pc   <= pc_nxt;
      ifid <= ifid_nxt;
      if (stall_inc && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && (flush_cnt != '1))
        flush_cnt <= flush_cnt + 1'b1;
    end
  end

  assign imem_addr   = pc;
  assign id_instr    = ifid.instr;
  assign id_pc_plus4 = ifid.pc_plus4;
  assign id_valid    = ifid.valid;
  assign id_opcode   = ifid.instr[31:26];
  assign id_funct    = ifid.instr[5:0];

endmodule

// File: tb/tb_if_id_stage.sv
// tb_if_id_stage: directed and randomized checks of if_id_stage
// against a cycle-level reference model of the fetch rules.
module tb_if_id_stage;
  localparam int unsigned CNT_W = 6;
  localparam logic [CNT_W-1:0] CMAX = '1;

  logic             clk;
  logic             rst_n;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_data;
  logic             stall;
  logic             jcond;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic [31:0]      id_instr;
  logic [31:0]      id_pc_plus4;
  logic             id_valid;
  logic [5:0]       id_opcode;
  logic [5:0]       id_funct;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic [31:0] mem [256];
  assign imem_data = mem[imem_addr[9:2]];

  logic [31:0]      m_pc;
  logic [31:0]      m_instr;
  logic [31:0]      m_pp4;
  logic             m_valid;
  logic [CNT_W-1:0] m_sc;
  logic [CNT_W-1:0] m_fc;

  int errors = 0;
  int checks = 0;

  if_id_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .jcond(jcond),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct(id_funct), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge: advance the reference model, then settle.
  task automatic tick();
    logic [31:0] word;
    @(posedge clk);
    word = mem[m_pc[9:2]];
    if (!rst_n) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pp4 = 32'h0;
      m_valid = 1'b0; m_sc = '0; m_fc = '0;
    end else if (branch_taken) begin
      m_pc = {branch_target[31:2], 2'b00};
      m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc != CMAX) m_fc = m_fc + 1'b1;
    end else if (stall) begin
      if (m_sc != CMAX) m_sc = m_sc + 1'b1;
    end else if (jcond && m_valid) begin
      m_pc = {m_pp4[31:28], m_instr[25:0], 2'b00};
      m_instr = 32'h0; m_valid = 1'b0;
      if (m_fc != CMAX) m_fc = m_fc + 1'b1;
    end else begin
      m_instr = word;
      m_pp4 = m_pc + 32'd4;
      m_pc = m_pc + 32'd4;
      m_valid = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; jcond = 0; branch_taken = 0;
    branch_target = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    checks++;
    if (imem_addr !== 32'h0 || id_valid !== 1'b0 ||
        id_instr !== 32'h0 || id_pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs: addr=%h v=%b instr=%h pp4=%h want 0",
               imem_addr, id_valid, id_instr, id_pc_plus4);
    end
    checks++;
    if (stall_cnt !== '0 || flush_cnt !== '0) begin
      errors++;
      $display("FAIL reset_cnt: sc=%0d fc=%0d want 0",
               stall_cnt, flush_cnt);
    end
    rst_n = 1;
    #1;
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++;
      $display("FAIL release_pc0: got %h want 0", imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h4) begin
      errors++;
      $display("FAIL release_pc4: got %h want 4", imem_addr);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++;
      $display("FAIL release_pc8: got %h want 8", imem_addr);
    end
  endtask

  task automatic test_sequential();
    mem[0] = 32'h8C01_0004;
    mem[1] = 32'h0000_0820;
    do_reset();
    tick();
    checks++;
    if (id_instr !== 32'h8C01_0004 || id_pc_plus4 !== 32'h4 ||
        id_opcode !== 6'd35 || id_funct !== 6'd4 ||
        id_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_edge1: instr=%h pp4=%h op=%0d fn=%0d v=%b",
               id_instr, id_pc_plus4, id_opcode, id_funct, id_valid);
    end
    tick();
    checks++;
    if (id_instr !== 32'h0000_0820 || id_pc_plus4 !== 32'h8 ||
        id_opcode !== 6'd0 || id_funct !== 6'h20) begin
      errors++;
      $display("FAIL seq_edge2: instr=%h pp4=%h op=%0d fn=%0d",
               id_instr, id_pc_plus4, id_opcode, id_funct);
    end
  endtask

  task automatic test_stall();
    mem[0] = 32'h8C01_0004;
    mem[1] = 32'h0000_0820;
    do_reset();
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (imem_addr !== 32'h4 || id_instr !== 32'h8C01_0004 ||
          id_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold%0d: addr=%h instr=%h v=%b want 4/8c010004/1",
                 i, imem_addr, id_instr, id_valid);
      end
    end
    checks++;
    if (stall_cnt !== 6'd3) begin
      errors++;
      $display("FAIL stall_cnt3: got %0d want 3", stall_cnt);
    end
    stall = 0;
    tick();
    checks++;
    if (imem_addr !== 32'h8 || id_instr !== 32'h0000_0820 ||
        id_pc_plus4 !== 32'h8) begin
      errors++;
      $display("FAIL stall_resume: addr=%h instr=%h pp4=%h",
               imem_addr, id_instr, id_pc_plus4);
    end
  endtask

  task automatic test_jump();
    mem[0] = 32'h2001_0001;
    mem[1] = 32'h0800_0010;
    mem[16] = 32'h2002_0002;
    do_reset();
    tick(); tick();
    stall = 1; jcond = 1;
    tick();
    checks++;
    if (imem_addr !== 32'h8 || id_valid !== 1'b1 ||
        flush_cnt !== '0) begin
      errors++;
      $display("FAIL jump_stalled: addr=%h v=%b fc=%0d want 8/1/0",
               imem_addr, id_valid, flush_cnt);
    end
    stall = 0;
    tick();
    checks++;
    if (imem_addr !== 32'h40 || id_valid !== 1'b0 ||
        id_instr !== 32'h0 || flush_cnt !== 6'd1) begin
      errors++;
      $display("FAIL jump_taken: addr=%h v=%b instr=%h fc=%0d want 40/0/0/1",
               imem_addr, id_valid, id_instr, flush_cnt);
    end
    tick();
    checks++;
    if (imem_addr !== 32'h44 || id_valid !== 1'b1 ||
        id_instr !== 32'h2002_0002 || flush_cnt !== 6'd1) begin
      errors++;
      $display("FAIL jump_bubble_ignored: addr=%h v=%b instr=%h fc=%0d",
               imem_addr, id_valid, id_instr, flush_cnt);
    end
    jcond = 0;
  endtask

  task automatic test_branch_priority();
    logic [CNT_W-1:0] sc0;
    logic [CNT_W-1:0] fc0;
    sc0 = m_sc;
    fc0 = m_fc;
    branch_taken = 1; branch_target = 32'h103;
    stall = 1; jcond = 1;
    tick();
    checks++;
    if (imem_addr !== 32'h100 || id_valid !== 1'b0 ||
        id_instr !== 32'h0) begin
      errors++;
      $display("FAIL branch_prio: addr=%h v=%b instr=%h want 100/0/0",
               imem_addr, id_valid, id_instr);
    end
    checks++;
    if (flush_cnt !== fc0 + 1'b1 || stall_cnt !== sc0) begin
      errors++;
      $display("FAIL branch_cnts: fc=%0d sc=%0d want %0d/%0d",
               flush_cnt, stall_cnt, fc0 + 1'b1, sc0);
    end
    idle_inputs();
  endtask

  task automatic test_wrap_sat();
    do_reset();
    branch_taken = 1; branch_target = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL branch_align: got %h want fffffffc", imem_addr);
    end
    idle_inputs();
    tick();
    checks++;
    if (imem_addr !== 32'h0 || id_pc_plus4 !== 32'h0 ||
        id_instr !== mem[255]) begin
      errors++;
      $display("FAIL pc_wrap: addr=%h pp4=%h instr=%h want 0/0/%h",
               imem_addr, id_pc_plus4, id_instr, mem[255]);
    end
    stall = 1;
    for (int i = 0; i < (1 << CNT_W) + 5; i++) tick();
    checks++;
    if (stall_cnt !== CMAX) begin
      errors++;
      $display("FAIL stall_sat: got %0d want %0d", stall_cnt, CMAX);
    end
    stall = 0;
    rst_n = 0; branch_taken = 1; branch_target = 32'h200;
    tick();
    checks++;
    if (imem_addr !== 32'h0 || flush_cnt !== '0 ||
        stall_cnt !== '0 || id_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_branch: addr=%h fc=%0d sc=%0d v=%b",
               imem_addr, flush_cnt, stall_cnt, id_valid);
    end
    rst_n = 1;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      stall         = ($urandom_range(3) == 0);
      jcond         = ($urandom_range(4) == 0);
      branch_taken  = ($urandom_range(9) == 0);
      branch_target = $urandom;
      rst_n         = ($urandom_range(49) != 0);
      tick();
      checks++;
      if (imem_addr !== m_pc || id_instr !== m_instr ||
          id_pc_plus4 !== m_pp4 || id_valid !== m_valid) begin
        errors++;
        $display("FAIL rand_regs@%0d: pc=%h/%h instr=%h/%h pp4=%h/%h v=%b/%b",
                 n, imem_addr, m_pc, id_instr, m_instr,
                 id_pc_plus4, m_pp4, id_valid, m_valid);
      end
      checks++;
      if (id_opcode !== m_instr[31:26] || id_funct !== m_instr[5:0] ||
          stall_cnt !== m_sc || flush_cnt !== m_fc) begin
        errors++;
        $display("FAIL rand_dec@%0d: op=%0d fn=%0d sc=%0d/%0d fc=%0d/%0d",
                 n, id_opcode, id_funct, stall_cnt, m_sc, flush_cnt, m_fc);
      end
    end
    rst_n = 1;
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    rst_n = 0;
    idle_inputs();
    m_pc = 0; m_instr = 0; m_pp4 = 0; m_valid = 0;
    m_sc = '0; m_fc = '0;
    test_reset();
    test_sequential();
    test_stall();
    test_jump();
    test_branch_priority();
    test_wrap_sat();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
